// File: rtl/braille_cell_entry.sv
// Braille keypad front end: synchronises and debounces SUBMIT, captures the 6-dot cell,
// encodes it to a 4-bit letter code and tracks the position within a 5-letter word.
module braille_cell_entry #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] dots_in,
   input  logic       submit_in,
   output logic [3:0] playeralph,
   output logic       valid,
   output logic       bad_cell,
   output logic [2:0] entry_idx,
   output logic       seq_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      EMIT    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [5:0]       r_dots_s1, r_dots_s2;
   logic             r_sub_s1, r_sub_s2;
   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [5:0]       r_cell, w_cell_next;
   logic [3:0]       r_alph, w_alph_next;
   logic             r_valid, w_valid_next;
   logic             r_bad, w_bad_next;
   logic [2:0]       r_idx, w_idx_next;
   logic             r_done, w_done_next;
   logic [3:0]       w_code;

   // Two-flop synchronisers; the FSM only ever looks at the second stage.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dots_s1 <= '0;
         r_dots_s2 <= '0;
         r_sub_s1  <= 1'b0;
         r_sub_s2  <= 1'b0;
      end else begin
         r_dots_s1 <= dots_in;
         r_dots_s2 <= r_dots_s1;
         r_sub_s1  <= submit_in;
         r_sub_s2  <= r_sub_s1;
      end
   end

   always_comb begin
      w_code = 4'h0;
      case (r_cell)
         6'h01: w_code = 4'h1;
         6'h03: w_code = 4'h2;
         6'h09: w_code = 4'h3;
         6'h19: w_code = 4'h4;
         6'h11: w_code = 4'h5;
         6'h0B: w_code = 4'h6;
         6'h1B: w_code = 4'h7;
         6'h13: w_code = 4'h8;
         6'h0A: w_code = 4'h9;
         6'h1A: w_code = 4'hA;
         6'h05: w_code = 4'hB;
         6'h07: w_code = 4'hC;
         6'h0D: w_code = 4'hD;
         6'h1D: w_code = 4'hE;
         6'h15: w_code = 4'hF;
         default: w_code = 4'h0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_cell_next  = r_cell;
      w_alph_next  = r_alph;
      w_valid_next = 1'b0;
      w_bad_next   = 1'b0;
      w_idx_next   = r_idx;
      w_done_next  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_sub_s2) begin
               w_state_next = PRESS;
               w_cnt_next   = '0;
            end
         end
         PRESS: begin
            if (!r_sub_s2) begin
               w_state_next = IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_next = EMIT;
               w_cell_next  = r_dots_s2;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         EMIT: begin
            // Unknown cells still count so the checker stays aligned with the player.
            w_valid_next = 1'b1;
            w_alph_next  = w_code;
            w_bad_next   = (w_code == 4'h0);
            w_state_next = RELEASE;
            w_cnt_next   = '0;
            if (r_idx == 3'd4) begin
               w_idx_next  = 3'd0;
               w_done_next = 1'b1;
            end else begin
               w_idx_next = r_idx + 3'd1;
            end
         end
         RELEASE: begin
            if (r_sub_s2) begin
               w_cnt_next = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: w_state_next = RELEASE;
      endcase
   end

   // Reset lands in RELEASE so a key held through reset has to be let go first.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= RELEASE;
         r_cnt   <= '0;
         r_cell  <= '0;
         r_alph  <= '0;
         r_valid <= 1'b0;
         r_bad   <= 1'b0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_cell  <= w_cell_next;
         r_alph  <= w_alph_next;
         r_valid <= w_valid_next;
         r_bad   <= w_bad_next;
         r_idx   <= w_idx_next;
         r_done  <= w_done_next;
      end
   end

   assign playeralph = r_alph;
   assign valid      = r_valid;
   assign bad_cell   = r_bad;
   assign entry_idx  = r_idx;
   assign seq_done   = r_done;

endmodule

// File: tb/tb_braille_cell_entry.sv
// Directed bench for braille_cell_entry with DEBOUNCE_CYCLES=4: latency, bounce,
// encoding, word wrap, unrecognised cells and reset behaviour.
module tb_braille_cell_entry;

   logic       clk;
   logic       rst;
   logic [5:0] dots_in;
   logic       submit_in;
   logic [3:0] playeralph;
   logic       valid;
   logic       bad_cell;
   logic [2:0] entry_idx;
   logic       seq_done;

   int checks      = 0;
   int failures    = 0;
   int valid_count = 0;

   braille_cell_entry #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dots_in   (dots_in),
      .submit_in (submit_in),
      .playeralph(playeralph),
      .valid     (valid),
      .bad_cell  (bad_cell),
      .entry_idx (entry_idx),
      .seq_done  (seq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid === 1'b1) valid_count <= valid_count + 1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_alph"}, 16'(playeralph), 16'd0);
      check({tag, "_valid"}, 16'(valid), 16'd0);
      check({tag, "_bad"}, 16'(bad_cell), 16'd0);
      check({tag, "_idx"}, 16'(entry_idx), 16'd0);
      check({tag, "_done"}, 16'(seq_done), 16'd0);
   endtask

   // Holds SUBMIT with the given dots until valid (bounded), checks the strobe
   // contents and width, then releases and waits for the FSM to return to IDLE.
   task automatic press(input logic [5:0] d, input int exp_code, input int exp_bad,
                        input int exp_idx, input int exp_done, input int exp_lat);
      int n;
      int v0;
      dots_in   = d;
      submit_in = 1'b1;
      v0 = valid_count;
      n  = 0;
      do begin
         tick();
         n++;
      end while (valid !== 1'b1 && n < 40);
      check("latency", 16'(n), 16'(exp_lat));
      check("code", 16'(playeralph), 16'(exp_code));
      check("bad_cell", 16'(bad_cell), 16'(exp_bad));
      check("entry_idx", 16'(entry_idx), 16'(exp_idx));
      check("seq_done", 16'(seq_done), 16'(exp_done));
      $display("press dots=%02h code=%0h bad=%0d idx=%0d done=%0d latency=%0d",
               d, playeralph, bad_cell, entry_idx, seq_done, n);
      dots_in = 6'h00;
      tick();
      check("valid_width", 16'(valid), 16'd0);
      check("bad_width", 16'(bad_cell), 16'd0);
      check("done_width", 16'(seq_done), 16'd0);
      repeat (6) tick();
      submit_in = 1'b0;
      repeat (12) tick();
      check("one_valid", 16'(valid_count - v0), 16'd1);
      check("code_held", 16'(playeralph), 16'(exp_code));
   endtask

   initial begin
      int v0;
      // Reset with SUBMIT held through and after it.
      rst       = 1'b0;
      dots_in   = 6'h01;
      submit_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all_zero("reset");
      end
      rst = 1'b1;
      repeat (20) tick();
      check("held_through_reset", 16'(valid_count), 16'd0);
      submit_in = 1'b0;
      repeat (10) tick();
      press(6'h01, 1, 0, 1, 0, 8);

      // Clean press of 'd'.
      press(6'h19, 4, 0, 2, 0, 8);

      // Bounce 1,0,1,0 then held: one valid, 8 cycles after the held edge.
      v0 = valid_count;
      dots_in = 6'h03;
      for (int i = 0; i < 4; i++) begin
         submit_in = (i % 2 == 0);
         tick();
      end
      press(6'h03, 2, 0, 3, 0, 8);
      check("bounce_total", 16'(valid_count - v0), 16'd1);

      // Fresh word: a b c d e, wrap on the fifth.
      rst = 1'b0;
      tick();
      check_all_zero("reset2");
      rst = 1'b1;
      repeat (12) tick();
      press(6'h01, 1, 0, 1, 0, 8);
      press(6'h03, 2, 0, 2, 0, 8);
      press(6'h09, 3, 0, 3, 0, 8);
      press(6'h19, 4, 0, 4, 0, 8);
      press(6'h11, 5, 0, 0, 1, 8);

      // Unrecognised cells, then a few more letters from the table.
      press(6'h3F, 0, 1, 1, 0, 8);
      press(6'h00, 0, 1, 2, 0, 8);
      press(6'h1D, 14, 0, 3, 0, 8);
      press(6'h15, 15, 0, 4, 0, 8);
      press(6'h0A, 9, 0, 0, 1, 8);

      // Reset while in PRESS with cnt=2.
      v0 = valid_count;
      dots_in   = 6'h1B;
      submit_in = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      tick();
      check_all_zero("reset_mid_press");
      tick();
      rst = 1'b1;
      repeat (20) tick();
      check("mid_press_no_valid", 16'(valid_count - v0), 16'd0);
      submit_in = 1'b0;
      repeat (10) tick();
      press(6'h1B, 7, 0, 1, 0, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
